// File: rtl/link_txn_ctrl.sv
// link_txn_ctrl: link-layer transaction sequencer (token -> data -> handshake) for up to 16 endpoints.
// Latency: a token sampled on cycle N changes state and registered outputs on N+1; turnaround is delay_threshold+1 cycles.
// Backpressure: no valid/ready path; per-endpoint ready/stall flags select NAK/STALL, and a wait timer aborts stalled exchanges.
// Ports: clk / async active-low rst_n; delay_threshold and time_threshold; ep_ready / ep_stall (one bit per endpoint);
//        rx_pid/rx_pid_en/rx_ep/rx_lt_eop_en/rx_crc_err from the receiver; tx_lp_eop_en from the transmitter;
//        time_out, rx_data_on, rx_handshake_on, tx_data_on, tx_hs_en, tx_hs_pid, tx_data_pid, d_oe, ep.
// Optional feature: define LINK_TXN_TOGGLE_EN for per-endpoint DATA0/DATA1 toggle tracking.
module link_txn_ctrl #(
  parameter int EP_NUM = 4,
  parameter int TMR_W  = 16,
  parameter int DLY_W  = 6
) (
  input  logic              i_link_txn_ctrl_clk,
  input  logic              i_link_txn_ctrl_rst_n,
  input  logic [DLY_W-1:0]  i_link_txn_ctrl_delay_threshold,
  input  logic [TMR_W-1:0]  i_link_txn_ctrl_time_threshold,
  input  logic [EP_NUM-1:0] i_link_txn_ctrl_ep_ready,
  input  logic [EP_NUM-1:0] i_link_txn_ctrl_ep_stall,
  input  logic [3:0]        i_link_txn_ctrl_rx_pid,
  input  logic              i_link_txn_ctrl_rx_pid_en,
  input  logic [3:0]        i_link_txn_ctrl_rx_ep,
  input  logic              i_link_txn_ctrl_rx_lt_eop_en,
  input  logic              i_link_txn_ctrl_rx_crc_err,
  input  logic              i_link_txn_ctrl_tx_lp_eop_en,
  output logic              o_link_txn_ctrl_time_out,
  output logic              o_link_txn_ctrl_rx_data_on,
  output logic              o_link_txn_ctrl_rx_handshake_on,
  output logic              o_link_txn_ctrl_tx_data_on,
  output logic              o_link_txn_ctrl_tx_hs_en,
  output logic [3:0]        o_link_txn_ctrl_tx_hs_pid,
  output logic [3:0]        o_link_txn_ctrl_tx_data_pid,
  output logic              o_link_txn_ctrl_d_oe,
  output logic [3:0]        o_link_txn_ctrl_ep
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    IDLE, RX_DATA, TURN_HS, TX_HS, TURN_DATA, TX_DATA, WAIT_HS
  } state_t;

  state_t           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [DLY_W-1:0] dly_q;
  logic             setup_q;

  // Select one endpoint flag by a 4-bit index; indices beyond EP_NUM read as 0.
  function automatic logic pick(input logic [EP_NUM-1:0] v, input logic [3:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < EP_NUM; i++) begin
      if (idx == 4'(i)) r = v[i];
    end
    return r;
  endfunction

  logic tok_ep_ok, tok_stall, tok_ready, cur_stall, cur_ready;
  logic is_data_pid;

  assign tok_ep_ok   = int'(i_link_txn_ctrl_rx_ep) < EP_NUM;
  assign tok_stall   = pick(i_link_txn_ctrl_ep_stall, i_link_txn_ctrl_rx_ep);
  assign tok_ready   = pick(i_link_txn_ctrl_ep_ready, i_link_txn_ctrl_rx_ep);
  assign cur_stall   = pick(i_link_txn_ctrl_ep_stall, o_link_txn_ctrl_ep);
  assign cur_ready   = pick(i_link_txn_ctrl_ep_ready, o_link_txn_ctrl_ep);
  assign is_data_pid = (i_link_txn_ctrl_rx_pid == PID_DATA0) || (i_link_txn_ctrl_rx_pid == PID_DATA1);

`ifdef LINK_TXN_TOGGLE_EN
  logic [EP_NUM-1:0] toggle_q;
  logic              data_odd_q;  // received data PID was DATA1
  logic [EP_NUM-1:0] ep_mask;
  logic              cur_toggle;
  assign ep_mask    = EP_NUM'(1) << o_link_txn_ctrl_ep;
  assign cur_toggle = pick(toggle_q, o_link_txn_ctrl_ep);
`endif

  always_ff @(posedge i_link_txn_ctrl_clk or negedge i_link_txn_ctrl_rst_n) begin
    if (!i_link_txn_ctrl_rst_n) begin
      state_q                         <= IDLE;
      tmr_q                           <= '0;
      dly_q                           <= '0;
      setup_q                         <= 1'b0;
      o_link_txn_ctrl_time_out        <= 1'b0;
      o_link_txn_ctrl_rx_data_on      <= 1'b0;
      o_link_txn_ctrl_rx_handshake_on <= 1'b0;
      o_link_txn_ctrl_tx_data_on      <= 1'b0;
      o_link_txn_ctrl_tx_hs_en        <= 1'b0;
      o_link_txn_ctrl_tx_hs_pid       <= 4'b0000;
      o_link_txn_ctrl_tx_data_pid     <= 4'b0000;
      o_link_txn_ctrl_d_oe            <= 1'b0;
      o_link_txn_ctrl_ep              <= 4'd0;
`ifdef LINK_TXN_TOGGLE_EN
      toggle_q                        <= '0;
      data_odd_q                      <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      o_link_txn_ctrl_time_out <= 1'b0;
      o_link_txn_ctrl_tx_hs_en <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_link_txn_ctrl_rx_pid_en && tok_ep_ok) begin
            if (i_link_txn_ctrl_rx_pid == PID_OUT || i_link_txn_ctrl_rx_pid == PID_SETUP) begin
              state_q                    <= RX_DATA;
              o_link_txn_ctrl_ep         <= i_link_txn_ctrl_rx_ep;
              setup_q                    <= (i_link_txn_ctrl_rx_pid == PID_SETUP);
              tmr_q                      <= '0;
              o_link_txn_ctrl_rx_data_on <= 1'b1;
`ifdef LINK_TXN_TOGGLE_EN
              data_odd_q                 <= 1'b0;
`endif
            end else if (i_link_txn_ctrl_rx_pid == PID_IN) begin
              o_link_txn_ctrl_ep   <= i_link_txn_ctrl_rx_ep;
              o_link_txn_ctrl_d_oe <= 1'b1;
              dly_q                <= '0;
              if (tok_stall) begin
                state_q                   <= TURN_HS;
                o_link_txn_ctrl_tx_hs_pid <= PID_STALL;
              end else if (!tok_ready) begin
                state_q                   <= TURN_HS;
                o_link_txn_ctrl_tx_hs_pid <= PID_NAK;
              end else begin
                state_q <= TURN_DATA;
              end
            end
          end
        end
        RX_DATA: begin
`ifdef LINK_TXN_TOGGLE_EN
          if (i_link_txn_ctrl_rx_pid_en && is_data_pid) data_odd_q <= i_link_txn_ctrl_rx_pid[3];
`endif
          // End of packet takes priority over a coincident timeout.
          if (i_link_txn_ctrl_rx_lt_eop_en) begin
            o_link_txn_ctrl_rx_data_on <= 1'b0;
            if (i_link_txn_ctrl_rx_crc_err) begin
              state_q <= IDLE;
            end else begin
              state_q                   <= TURN_HS;
              o_link_txn_ctrl_d_oe      <= 1'b1;
              dly_q                     <= '0;
              o_link_txn_ctrl_tx_hs_pid <= PID_ACK;
              if (setup_q) begin
`ifdef LINK_TXN_TOGGLE_EN
                toggle_q <= toggle_q | ep_mask;
`endif
              end else if (cur_stall) begin
                o_link_txn_ctrl_tx_hs_pid <= PID_STALL;
              end else if (!cur_ready) begin
                o_link_txn_ctrl_tx_hs_pid <= PID_NAK;
              end else begin
`ifdef LINK_TXN_TOGGLE_EN
                // A PID that disagrees with the toggle is a retransmission: ACK it but keep the toggle.
                if (data_odd_q == cur_toggle) toggle_q <= toggle_q ^ ep_mask;
`endif
              end
            end
          end else if (tmr_q == i_link_txn_ctrl_time_threshold) begin
            o_link_txn_ctrl_time_out   <= 1'b1;
            o_link_txn_ctrl_rx_data_on <= 1'b0;
            state_q                    <= IDLE;
          end else if (tmr_q != '1) begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        TURN_HS: begin
          if (dly_q == i_link_txn_ctrl_delay_threshold) begin
            state_q                  <= TX_HS;
            o_link_txn_ctrl_tx_hs_en <= 1'b1;
          end else begin
            dly_q <= dly_q + 1'b1;
          end
        end
        TX_HS: begin
          if (i_link_txn_ctrl_tx_lp_eop_en) begin
            state_q              <= IDLE;
            o_link_txn_ctrl_d_oe <= 1'b0;
          end
        end
        TURN_DATA: begin
          if (dly_q == i_link_txn_ctrl_delay_threshold) begin
            state_q                    <= TX_DATA;
            o_link_txn_ctrl_tx_data_on <= 1'b1;
`ifdef LINK_TXN_TOGGLE_EN
            o_link_txn_ctrl_tx_data_pid <= cur_toggle ? PID_DATA1 : PID_DATA0;
`else
            o_link_txn_ctrl_tx_data_pid <= PID_DATA0;
`endif
          end else begin
            dly_q <= dly_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (i_link_txn_ctrl_tx_lp_eop_en) begin
            state_q                         <= WAIT_HS;
            o_link_txn_ctrl_tx_data_on      <= 1'b0;
            o_link_txn_ctrl_d_oe            <= 1'b0;
            o_link_txn_ctrl_rx_handshake_on <= 1'b1;
            tmr_q                           <= '0;
          end
        end
        WAIT_HS: begin
          if (i_link_txn_ctrl_rx_pid_en) begin
            state_q                         <= IDLE;
            o_link_txn_ctrl_rx_handshake_on <= 1'b0;
`ifdef LINK_TXN_TOGGLE_EN
            if (i_link_txn_ctrl_rx_pid == PID_ACK) toggle_q <= toggle_q ^ ep_mask;
`endif
          end else if (tmr_q == i_link_txn_ctrl_time_threshold) begin
            o_link_txn_ctrl_time_out        <= 1'b1;
            o_link_txn_ctrl_rx_handshake_on <= 1'b0;
            state_q                         <= IDLE;
          end else if (tmr_q != '1) begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef LINK_TXN_TOGGLE_EN
  // Data PID value only matters when toggles are tracked.
  logic unused_data_pid;
  assign unused_data_pid = is_data_pid;
`endif

endmodule

// File: tb/tb_link_txn_ctrl.sv
// Bench for link_txn_ctrl: directed transactions push expected events (d_oe rise, handshake pulse,
// data start, timeout) into a queue; a negedge monitor pops and compares kind, PID and cycle.
module tb_link_txn_ctrl;
  localparam int EP_NUM = 4;
  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_SETUP = 4'b1101, P_DATA0 = 4'b0011,
                         P_DATA1 = 4'b1011, P_ACK = 4'b0010, P_NAK = 4'b1010, P_STALL = 4'b1110;
`ifdef LINK_TXN_TOGGLE_EN
  localparam bit TG = 1'b1;
`else
  localparam bit TG = 1'b0;
`endif
  localparam int K_DOE = 0, K_HS = 1, K_DATA = 2, K_TOUT = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] dly_v = 6'd5;
  logic [15:0] tmr_v = 16'd200;
  logic [EP_NUM-1:0] ep_ready = '1, ep_stall = '0;
  logic [3:0] rx_pid = '0, rx_ep = '0;
  logic rx_pid_en = 0, rx_lt_eop = 0, rx_crc_err = 0, tx_lp_eop = 0;
  logic time_out, rx_data_on, rx_hs_on, tx_data_on, tx_hs_en, d_oe;
  logic [3:0] tx_hs_pid, tx_data_pid, ep_o;

  link_txn_ctrl dut (
    .i_link_txn_ctrl_clk(clk), .i_link_txn_ctrl_rst_n(rst_n),
    .i_link_txn_ctrl_delay_threshold(dly_v), .i_link_txn_ctrl_time_threshold(tmr_v),
    .i_link_txn_ctrl_ep_ready(ep_ready), .i_link_txn_ctrl_ep_stall(ep_stall),
    .i_link_txn_ctrl_rx_pid(rx_pid), .i_link_txn_ctrl_rx_pid_en(rx_pid_en),
    .i_link_txn_ctrl_rx_ep(rx_ep), .i_link_txn_ctrl_rx_lt_eop_en(rx_lt_eop),
    .i_link_txn_ctrl_rx_crc_err(rx_crc_err), .i_link_txn_ctrl_tx_lp_eop_en(tx_lp_eop),
    .o_link_txn_ctrl_time_out(time_out), .o_link_txn_ctrl_rx_data_on(rx_data_on),
    .o_link_txn_ctrl_rx_handshake_on(rx_hs_on), .o_link_txn_ctrl_tx_data_on(tx_data_on),
    .o_link_txn_ctrl_tx_hs_en(tx_hs_en), .o_link_txn_ctrl_tx_hs_pid(tx_hs_pid),
    .o_link_txn_ctrl_tx_data_pid(tx_data_pid), .o_link_txn_ctrl_d_oe(d_oe),
    .o_link_txn_ctrl_ep(ep_o)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  typedef struct { int kind; logic [3:0] pid; int cyc; } exp_t;
  exp_t exp_q[$];

  task automatic push(input int k, input logic [3:0] p, input int c);
    exp_t x;
    x.kind = k; x.pid = p; x.cyc = c;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic got(input int k, input logic [3:0] p);
    exp_t x;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind %0d pid %b at cycle %0d with nothing expected", k, p, cyc);
    end else begin
      x = exp_q.pop_front();
      if (x.kind != k || x.pid !== p || x.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind %0d pid %b cycle %0d, expected kind %0d pid %b cycle %0d",
                 k, p, cyc, x.kind, x.pid, x.cyc);
      end
    end
  endtask

  // Monitor: observes outputs on the falling edge.
  logic prev_doe = 1'b0, prev_tdo = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (d_oe && !prev_doe)       got(K_DOE, 4'h0);
      if (tx_data_on && !prev_tdo) got(K_DATA, tx_data_pid);
      if (tx_hs_en)                got(K_HS, tx_hs_pid);
      if (time_out)                got(K_TOUT, 4'h0);
    end
    prev_doe = d_oe;
    prev_tdo = tx_data_on;
  end

  // Drivers: each input pulse is sampled by the DUT on clock edge number e.
  task automatic sync_to(input int e);
    while (cyc < e - 1) begin @(posedge clk); #1; end
  endtask
  task automatic wait_to(input int e);
    while (cyc < e) begin @(posedge clk); #1; end
  endtask
  task automatic drive_pid(input logic [3:0] p, input logic [3:0] epn, input int e);
    sync_to(e); rx_pid = p; rx_ep = epn; rx_pid_en = 1'b1;
    @(posedge clk); #1; rx_pid_en = 1'b0;
  endtask
  task automatic drive_lt_eop(input bit crc, input int e);
    sync_to(e); rx_lt_eop = 1'b1; rx_crc_err = crc;
    @(posedge clk); #1; rx_lt_eop = 1'b0; rx_crc_err = 1'b0;
  endtask
  task automatic drive_tx_eop(input int e);
    sync_to(e); tx_lp_eop = 1'b1;
    @(posedge clk); #1; tx_lp_eop = 1'b0;
  endtask

  // Host-to-device transaction: token, data PID, end of packet, then expected handshake.
  task automatic out_txn(input logic [3:0] tok, input logic [3:0] epn, input logic [3:0] dpid,
                         input bit crc, input logic [3:0] hs, input string nm);
    int e, d;
    e = cyc + 2; d = int'(dly_v);
    drive_pid(tok, epn, e);
    chk({nm, "_ep"}, 32'(ep_o), 32'(epn));
    chk({nm, "_rx_data_on"}, 32'(rx_data_on), 32'd1);
    drive_pid(dpid, epn, e + 2);
    drive_lt_eop(crc, e + 4);
    if (crc) begin
      chk({nm, "_crc_rx_off"}, 32'(rx_data_on), 32'd0);
      chk({nm, "_crc_doe"}, 32'(d_oe), 32'd0);
      wait_to(e + d + 8);
    end else begin
      push(K_DOE, 4'h0, e + 4);
      push(K_HS, hs, e + 5 + d);
      drive_tx_eop(e + 8 + d);
      chk({nm, "_doe_release"}, 32'(d_oe), 32'd0);
    end
  endtask

  // Device-to-host: mode 0 handshake only, 1 data+ACK, 2 data+timeout, 3 data+NAK from host.
  task automatic in_txn(input logic [3:0] epn, input logic [3:0] pid, input int mode, input string nm);
    int e, d, ee;
    e = cyc + 2; d = int'(dly_v);
    drive_pid(P_IN, epn, e);
    push(K_DOE, 4'h0, e);
    if (mode == 0) begin
      push(K_HS, pid, e + d + 1);
      drive_tx_eop(e + d + 4);
      chk({nm, "_doe_release"}, 32'(d_oe), 32'd0);
    end else begin
      push(K_DATA, pid, e + d + 1);
      ee = e + d + 4;
      drive_tx_eop(ee);
      chk({nm, "_hs_on"}, 32'(rx_hs_on), 32'd1);
      chk({nm, "_doe_rx"}, 32'(d_oe), 32'd0);
      if (mode == 2) begin
        push(K_TOUT, 4'h0, ee + int'(tmr_v) + 1);
        wait_to(ee + int'(tmr_v) + 3);
      end else begin
        drive_pid((mode == 1) ? P_ACK : P_NAK, 4'd0, ee + 2);
      end
      chk({nm, "_hs_off"}, 32'(rx_hs_on), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({time_out, rx_data_on, rx_hs_on, tx_data_on, tx_hs_en,
                              tx_hs_pid, tx_data_pid, d_oe, ep_o}), 32'd0);
    rst_n = 1'b1;

    // OUT ep1 DATA0 with 5-cycle turnaround, then duplicate DATA0.
    out_txn(P_OUT, 4'd1, P_DATA0, 1'b0, P_ACK, "out_ep1");
    out_txn(P_OUT, 4'd1, P_DATA0, 1'b0, P_ACK, "out_ep1_dup");
    in_txn(4'd1, TG ? P_DATA1 : P_DATA0, 1, "in_ep1");
    in_txn(4'd1, P_DATA0, 3, "in_ep1_nak");
    in_txn(4'd1, P_DATA0, 1, "in_ep1_again");

    // IN ep2: not ready, stalled, then data.
    ep_ready[2] = 1'b0;
    in_txn(4'd2, P_NAK, 0, "in_ep2_nak");
    ep_stall[2] = 1'b1;
    in_txn(4'd2, P_STALL, 0, "in_ep2_stall_nrdy");
    ep_ready[2] = 1'b1;
    in_txn(4'd2, P_STALL, 0, "in_ep2_stall");
    ep_stall[2] = 1'b0;
    in_txn(4'd2, P_DATA0, 1, "in_ep2_data");
    in_txn(4'd2, TG ? P_DATA1 : P_DATA0, 1, "in_ep2_next");

    // OUT handshakes for stalled / not-ready endpoint, SETUP always ACKed.
    ep_stall[3] = 1'b1;
    out_txn(P_OUT, 4'd3, P_DATA0, 1'b0, P_STALL, "out_ep3_stall");
    ep_stall[3] = 1'b0; ep_ready[3] = 1'b0;
    out_txn(P_OUT, 4'd3, P_DATA0, 1'b0, P_NAK, "out_ep3_nak");
    out_txn(P_SETUP, 4'd3, P_DATA0, 1'b0, P_ACK, "setup_ep3");
    ep_ready[3] = 1'b1;
    in_txn(4'd3, TG ? P_DATA1 : P_DATA0, 1, "in_ep3_after_setup");

    // Zero turnaround threshold: one cycle in TURN_HS.
    dly_v = 6'd0;
    out_txn(P_OUT, 4'd0, P_DATA1, 1'b0, P_ACK, "out_ep0_dly0");
    dly_v = 6'd5;

    // Timeouts with threshold 20.
    tmr_v = 16'd20;
    in_txn(4'd0, P_DATA0, 2, "in_ep0_tout");
    in_txn(4'd0, P_DATA0, 1, "in_ep0_after_tout");
    e = cyc + 2;
    drive_pid(P_OUT, 4'd2, e);
    push(K_TOUT, 4'h0, e + 21);
    wait_to(e + 23);
    chk("rx_tout_rx_off", 32'(rx_data_on), 32'd0);
    // End of packet on the timeout cycle wins.
    e = cyc + 2;
    drive_pid(P_OUT, 4'd2, e);
    drive_pid(P_DATA0, 4'd2, e + 2);
    drive_lt_eop(1'b0, e + 21);
    push(K_DOE, 4'h0, e + 21);
    push(K_HS, P_ACK, e + 27);
    drive_tx_eop(e + 30);
    tmr_v = 16'd200;

    // CRC error and out-of-range endpoint.
    out_txn(P_OUT, 4'd0, P_DATA0, 1'b1, P_ACK, "out_ep0_crc");
    e = cyc + 2;
    drive_pid(P_OUT, 4'd7, e);
    chk("ep7_ignored_rx", 32'(rx_data_on), 32'd0);
    chk("ep7_ignored_ep", 32'(ep_o), 32'd0);
    drive_pid(P_IN, 4'd7, e + 2);
    wait_to(e + 12);
    chk("ep7_ignored_doe", 32'(d_oe), 32'd0);

    // Reset in the middle of TX_DATA.
    e = cyc + 2;
    drive_pid(P_IN, 4'd0, e);
    push(K_DOE, 4'h0, e);
    push(K_DATA, TG ? P_DATA1 : P_DATA0, e + 6);
    wait_to(e + 7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({time_out, rx_data_on, rx_hs_on, tx_data_on, tx_hs_en,
                                    tx_hs_pid, tx_data_pid, d_oe, ep_o}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_txn(4'd0, P_DATA0, 1, "in_ep0_after_reset");

    wait_to(cyc + 5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/link_txn_ctrl.md
LINK_TXN_CTRL -- requirements
Module: link_txn_ctrl

Interface
REQ-001 SHALL have parameter EP_NUM, default 4, number of endpoints (legal range 1..16).
REQ-002 SHALL have parameter TMR_W, default 16, timeout counter width.
REQ-003 SHALL have parameter DLY_W, default 6, turnaround counter width.
REQ-004 Clock: i_link_txn_ctrl_clk, in, 1, single clock, rising edge.
REQ-005 Reset: i_link_txn_ctrl_rst_n, in, 1, asynchronous, active-low.
REQ-006 i_link_txn_ctrl_delay_threshold, in, DLY_W, turnaround cycles before transmit.
REQ-007 i_link_txn_ctrl_time_threshold, in, TMR_W, timeout cycles.
REQ-008 i_link_txn_ctrl_ep_ready / i_link_txn_ctrl_ep_stall, in, EP_NUM each, per-endpoint buffer ready / halt flags.
REQ-009 i_link_txn_ctrl_rx_pid (4), rx_pid_en (1), rx_ep (4), rx_lt_eop_en (1), rx_crc_err (1, valid with rx_lt_eop_en), all inputs.
REQ-010 i_link_txn_ctrl_tx_lp_eop_en, in, 1, end of transmitted packet.
REQ-011 Outputs: o_link_txn_ctrl_time_out (1, pulse), rx_data_on (1), rx_handshake_on (1), tx_data_on (1), tx_hs_en (1, pulse), tx_hs_pid (4), tx_data_pid (4), d_oe (1, 1 = transmit), ep (4, latched endpoint).

Function
REQ-012 PIDs: OUT 0001, IN 1001, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
REQ-013 FSM states: IDLE, RX_DATA, TURN_HS, TX_HS, TURN_DATA, TX_DATA, WAIT_HS.
REQ-014 IDLE: rx_pid_en with OUT/SETUP and rx_ep<EP_NUM -> RX_DATA, latch rx_ep into o_ep; any other PID, or rx_ep>=EP_NUM, is ignored.
REQ-015 IDLE, IN token: ep_stall[ep] -> TURN_HS with STALL; else !ep_ready[ep] -> TURN_HS with NAK; else -> TURN_DATA.
REQ-016 RX_DATA: rx_data_on=1; rx_pid_en with DATA0/DATA1 latches data PID.
REQ-017 RX_DATA, rx_lt_eop_en: crc_err -> IDLE with no handshake; SETUP -> ACK and set toggle[ep]=1; OUT with stall -> STALL; OUT with !ready -> NAK; OUT with data PID != toggle[ep] -> ACK, no flip (duplicate); otherwise ACK and flip toggle[ep]; all non-error cases -> TURN_HS.
REQ-018 TURN_*: d_oe=1 on entry; delay counter starts at 0; exit to TX_* in the cycle the counter equals delay_threshold (threshold 0 = one cycle).
REQ-019 TX_HS: tx_hs_en pulses exactly one cycle on entry, tx_hs_pid held; tx_lp_eop_en -> IDLE, d_oe=0 next cycle.
REQ-020 TX_DATA: tx_data_on=1, tx_data_pid = DATA1 if toggle[ep] else DATA0; tx_lp_eop_en -> WAIT_HS, d_oe=0.
REQ-021 WAIT_HS: rx_handshake_on=1; rx_pid_en with ACK -> flip toggle[ep], IDLE; any other PID -> IDLE, no flip.
REQ-022 Timer: TMR_W bits, cleared on entry to RX_DATA/WAIT_HS, increments there, saturates at all-ones; timer==time_threshold -> time_out one-cycle pulse, -> IDLE.
REQ-023 Simultaneous events: lt_eop or ACK in the same cycle as timeout -> the event wins, no time_out; rx_pid_en in TURN/TX states ignored.
REQ-024 Latency: token accepted on cycle N -> state change visible N+1; all outputs registered.

Reset
REQ-025 On reset: state IDLE, all toggles 0, all counters 0, every output 0 (d_oe=0 receive, pids 0000); mid-transaction reset aborts immediately with no pulse.

Configuration
REQ-026 Macro LINK_TXN_TOGGLE_EN: defined -> per-endpoint toggle tracking per REQ-017/020/021; undefined -> no toggle storage, every OUT data PID accepted with ACK, tx_data_pid always DATA0, SETUP/ACK do not alter state.

Verification
REQ-027 OUT ep1, DATA0, good CRC, ready, delay 5 -> d_oe high 6 cycles before tx_hs_en, pid 0010, toggle[1]=1.
REQ-028 Repeat DATA0 to ep1 -> ACK, toggle[1] stays 1 (duplicate).
REQ-029 IN ep2, ep_ready=0 -> NAK; ep_stall=1 -> STALL; ep_ready=1, toggle 0 -> tx_data_pid 0011, ACK -> toggle 1.
REQ-030 IN ep0 data sent, no handshake, time_threshold 20 -> time_out pulse 21 cycles after lp_eop, toggle unchanged.
REQ-031 OUT ep0 with crc_err -> no tx_hs_en, IDLE; token rx_ep=7 with EP_NUM=4 -> ignored.
REQ-032 Reset asserted in TX_DATA -> all outputs 0 asynchronously, next IN ep0 -> DATA0.
